// File: rtl/maxpool_requant_pkg.sv
// rtl/maxpool_requant_pkg.sv - shared sizes and sample types for the pooling stage
package pool_pkg;

    localparam int OFM_W_DEF          = 12;
    localparam int OFM_H_DEF          = 12;
    localparam int IN_W_DEF           = 36;
    localparam int OUT_W_DEF          = 16;
    localparam int SHIFT_DEF          = 4;
    localparam int POOL_OUT_PER_FRAME = (OFM_W_DEF / 2) * (OFM_H_DEF / 2);

    typedef logic [OUT_W_DEF-1:0] ifm_sample_t;
    typedef logic [IN_W_DEF-1:0]  ofm_sample_t;

endpackage

// File: rtl/maxpool_requant_if.sv
// rtl/maxpool_requant_if.sv - OFM input stream and pooled output stream bundle
interface maxpool_requant_if
    import pool_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
);
    logic             in_valid;
    logic [IN_W-1:0]  In_OFM;
    logic             out_valid;
    logic [OUT_W-1:0] Out_Pool;
    logic             frame_done;

    // master drives OFM samples and observes the pooled stream
    modport master (
        output in_valid, In_OFM,
        input  out_valid, Out_Pool, frame_done
    );

    modport slave (
        input  in_valid, In_OFM,
        output out_valid, Out_Pool, frame_done
    );
endinterface

// File: rtl/requant_sat.sv
// rtl/requant_sat.sv - logical right shift followed by unsigned saturation
module requant_sat #(
    parameter int IN_W  = 36,
    parameter int OUT_W = 16,
    parameter int SHIFT = 4
) (
    input  logic [IN_W-1:0]  d_i,
    output logic [OUT_W-1:0] q_o
);
    logic [IN_W-1:0] shifted;
    logic            overflow;

    assign shifted  = d_i >> SHIFT;
    assign overflow = (shifted >> OUT_W) != '0;
    assign q_o      = overflow ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];
endmodule

// File: rtl/maxpool_requant.sv
// rtl/maxpool_requant.sv - 2x2/stride-2 max pooling of a raster OFM stream with 16-bit requant
module maxpool_requant
    import pool_pkg::*;
#(
    parameter int OFM_W = OFM_W_DEF,
    parameter int OFM_H = OFM_H_DEF,
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int SHIFT = SHIFT_DEF
) (
    input logic              clk,
    input logic              rst,
    maxpool_requant_if.slave bus
);
    localparam int CW    = (OFM_W > 2) ? $clog2(OFM_W) : 1;
    localparam int RW    = (OFM_H > 2) ? $clog2(OFM_H) : 1;
    localparam int LB_N  = OFM_W / 2;
    localparam int LB_AW = (LB_N > 1) ? $clog2(LB_N) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(OFM_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(OFM_H - 1);

    generate
        if ((OFM_W % 2) != 0 || (OFM_H % 2) != 0) begin : g_bad_geometry
            $error("maxpool_requant: OFM_W and OFM_H must both be even");
        end
    endgenerate

    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [IN_W-1:0]  hold_q, hold_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] pool_q, pool_d;
    logic             frame_done_q, frame_done_d;

    // holds the max of the top pair of each window until the bottom row arrives
    logic [IN_W-1:0]  linebuf [LB_N];

    logic [IN_W-1:0]  sample;
    logic [LB_AW-1:0] lb_idx;
    logic [IN_W-1:0]  lb_rd;
    logic [IN_W-1:0]  pair_max;
    logic [IN_W-1:0]  win_max;
    logic [OUT_W-1:0] win_q;
    logic             lb_we;

    assign sample   = bus.In_OFM;
    assign lb_idx   = LB_AW'(col_q >> 1);
    assign lb_rd    = linebuf[lb_idx];
    assign pair_max = (sample > hold_q) ? sample : hold_q;
    assign win_max  = (lb_rd > pair_max) ? lb_rd : pair_max;

    requant_sat #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_requant (
        .d_i (win_max),
        .q_o (win_q)
    );

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        hold_d       = hold_q;
        out_valid_d  = 1'b0;
        pool_d       = pool_q;
        frame_done_d = 1'b0;
        lb_we        = 1'b0;
        if (bus.in_valid) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            if (!col_q[0]) begin
                hold_d = sample;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                out_valid_d  = 1'b1;
                pool_d       = win_q;
                frame_done_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            hold_q       <= '0;
            out_valid_q  <= 1'b0;
            pool_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            hold_q       <= hold_d;
            out_valid_q  <= out_valid_d;
            pool_q       <= pool_d;
            frame_done_q <= frame_done_d;
        end
    end

    // contents need no reset: every entry is written on an even row before the odd row reads it
    always_ff @(posedge clk) begin
        if (!rst && lb_we) begin
            linebuf[lb_idx] <= pair_max;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.Out_Pool   = pool_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_maxpool_requant.sv
// tb/tb_maxpool_requant.sv - randomized and directed checks of maxpool_requant against a frame-array model
module tb_maxpool_requant;
    import pool_pkg::*;

    localparam int W  = OFM_W_DEF;
    localparam int H  = OFM_H_DEF;
    localparam int NS = W * H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    maxpool_requant_if #(.IN_W(IN_W_DEF), .OUT_W(OUT_W_DEF)) bus ();

    maxpool_requant dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // model: whole frame kept as a flat raster array
    logic [35:0] frame_mem [NS];
    int          pos = 0;
    logic        exp_valid = 1'b0;
    logic [15:0] exp_val = '0;
    logic        exp_fd = 1'b0;

    logic [15:0] got [$];
    logic        got_fd [$];

    function automatic logic [15:0] requant(input logic [35:0] m);
        logic [35:0] q;
        q = m / 16;
        return (q > 36'd65535) ? 16'hFFFF : q[15:0];
    endfunction

    function automatic logic [35:0] max2(input logic [35:0] a, input logic [35:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [15:0] window_result(input int p, input logic [35:0] br);
        return requant(max2(max2(frame_mem[p-W-1], frame_mem[p-W]), max2(frame_mem[p-1], br)));
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            pos       <= 0;
            exp_valid <= 1'b0;
            exp_fd    <= 1'b0;
        end else if (bus.in_valid) begin
            frame_mem[pos] <= bus.In_OFM;
            exp_valid      <= ((pos / W) % 2 == 1) && ((pos % W) % 2 == 1);
            exp_fd         <= (pos == NS - 1);
            if (((pos / W) % 2 == 1) && ((pos % W) % 2 == 1))
                exp_val <= window_result(pos, bus.In_OFM);
            pos <= (pos == NS - 1) ? 0 : pos + 1;
        end else begin
            exp_valid <= 1'b0;
            exp_fd    <= 1'b0;
        end
    end

    always @(negedge clk) begin
        checks++;
        if (bus.out_valid !== exp_valid) begin
            failures++;
            $display("FAIL out_valid t=%0t got=%b exp=%b", $time, bus.out_valid, exp_valid);
        end
        checks++;
        if (bus.frame_done !== (exp_valid & exp_fd)) begin
            failures++;
            $display("FAIL frame_done t=%0t got=%b exp=%b", $time, bus.frame_done, exp_valid & exp_fd);
        end
        if (exp_valid) begin
            checks++;
            if (bus.Out_Pool !== exp_val) begin
                failures++;
                $display("FAIL Out_Pool t=%0t got=%h exp=%h", $time, bus.Out_Pool, exp_val);
            end
        end
        if (bus.out_valid === 1'b1) begin
            got.push_back(bus.Out_Pool);
            got_fd.push_back(bus.frame_done);
        end
    end

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, act, req);
        end
    endtask

    task automatic drive(input logic v, input logic [35:0] d);
        @(negedge clk);
        bus.in_valid = v;
        bus.In_OFM   = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, {$urandom, $urandom});
    endtask

    function automatic logic [35:0] stim(input int mode, input int r, input int c, input int off);
        int w;
        int p;
        case (mode)
            0: return 36'((r * W + c + off) * 16);
            1: begin
                w = (r / 2) * (W / 2) + c / 2;
                p = (r % 2) * 2 + (c % 2);
                return (p == w % 4) ? 36'h100 : 36'h0;
            end
            2: return 36'h10_0000;
            3: return 36'hFFFF0;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // gap: 0 none, 1 alternate + random extra idles
    task automatic run_frame(input int mode, input int off, input int gap, input int nsamp);
        for (int i = 0; i < nsamp; i++) begin
            drive(1'b1, stim(mode, i / W, i % W, off));
            if (gap != 0) idle((i % 2 == 0) ? 1 : int'($urandom_range(0, 3)));
        end
    endtask

    function automatic int ramp_k(input int k);
        return (2 * (k / 6) + 1) * 12 + 2 * (k % 6) + 1;
    endfunction

    task automatic check_ramp(input string name, input int base, input int add);
        for (int k = 0; k < 36; k++) check(name, got[base + k], ramp_k(k) + add);
    endtask

    int fd_n;

    initial begin
        bus.in_valid = 1'b0;
        bus.In_OFM   = '0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_Out_Pool", bus.Out_Pool, 0);
        check("reset_frame_done", bus.frame_done, 0);
        rst = 1'b0;

        // ramp
        got.delete(); got_fd.delete();
        run_frame(0, 0, 0, NS); idle(3);
        check("ramp_count", got.size(), 36);
        check("ramp_first", got[0], 13);
        check("ramp_second", got[1], 15);
        check("ramp_row2", got[6], 37);
        check("ramp_last", got[35], 143);
        check("ramp_fd_last", got_fd[35], 1);
        check("ramp_fd_early", got_fd[34], 0);
        check_ramp("ramp_k", 0, 0);

        // max position
        got.delete(); got_fd.delete();
        run_frame(1, 0, 0, NS); idle(3);
        check("maxpos_count", got.size(), 36);
        foreach (got[k]) check("maxpos_val", got[k], 16);

        // saturation and exact full scale
        got.delete(); got_fd.delete();
        run_frame(2, 0, 0, NS); idle(3);
        check("sat_count", got.size(), 36);
        foreach (got[k]) check("sat_val", got[k], 16'hFFFF);
        got.delete(); got_fd.delete();
        run_frame(3, 0, 0, NS); idle(3);
        check("exact_count", got.size(), 36);
        foreach (got[k]) check("exact_val", got[k], 16'hFFFF);

        // gaps
        got.delete(); got_fd.delete();
        run_frame(0, 0, 1, NS); idle(3);
        check("gap_count", got.size(), 36);
        check_ramp("gap_k", 0, 0);

        // back-to-back frames
        got.delete(); got_fd.delete();
        run_frame(0, 0, 0, NS);
        run_frame(0, 1000, 0, NS); idle(3);
        check("b2b_count", got.size(), 72);
        check_ramp("b2b_f1", 0, 0);
        check_ramp("b2b_f2", 36, 1000);
        fd_n = 0;
        foreach (got_fd[k]) fd_n += int'(got_fd[k]);
        check("b2b_fd_total", fd_n, 2);
        check("b2b_fd_36", got_fd[35], 1);
        check("b2b_fd_72", got_fd[71], 1);

        // mid-frame reset with a sample on the reset cycle
        got.delete(); got_fd.delete();
        run_frame(0, 0, 0, 50);
        @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.In_OFM   = 36'hF_FFFF_FFFF;
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        run_frame(0, 0, 0, NS); idle(3);
        check("midrst_count", got.size(), 48);
        check_ramp("midrst_post", 12, 0);

        // randomized data with random gaps
        got.delete(); got_fd.delete();
        run_frame(4, 0, 1, NS);
        run_frame(4, 0, 0, NS); idle(3);
        check("rand_count", got.size(), 72);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
